// File: rtl/led_matrix_scanner.sv
// Double-buffered ROWS x COLS LED matrix scan driver with per-frame PWM brightness and post-reset hold.
// Optional macro LED_SCAN_GHOST_BLANK_EN blanks the columns on the first cycle of every row dwell.
module led_matrix_scanner #(
   parameter int ROWS       = 8,
   parameter int COLS       = 8,
   parameter int PWM_BITS   = 3,
   parameter int SLOT_LEN   = 128,
   parameter int POR_CYCLES = 4
) (
   input  logic                   system_clk,
   input  logic                   rst,
   input  logic [ROWS*COLS-1:0]   fb_in,
   input  logic                   fb_load,
   input  logic [PWM_BITS-1:0]    brightness,
   output logic                   fb_ready,
   output logic                   frame_start,
   output logic [ROWS-1:0]        row,
   output logic [COLS-1:0]        col
);

   localparam int IDX_W  = $clog2(ROWS);
   localparam int CYC_W  = $clog2(SLOT_LEN);
   localparam int HOLD_W = $clog2(POR_CYCLES + 1);

   localparam logic [IDX_W-1:0]    LAST_ROW  = IDX_W'(ROWS - 1);
   localparam logic [CYC_W-1:0]    LAST_CYC  = CYC_W'(SLOT_LEN - 1);
   localparam logic [PWM_BITS-1:0] LAST_SLOT = {PWM_BITS{1'b1}};
   localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(POR_CYCLES);

   typedef enum logic [0:0] {
      HOLD = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                 state_r;
   logic [HOLD_W-1:0]      hold_cnt_r;
   logic [IDX_W-1:0]       row_idx_r;
   logic [PWM_BITS-1:0]    slot_r;
   logic [CYC_W-1:0]       cyc_r;
   logic [ROWS*COLS-1:0]   disp_r;
   logic [ROWS*COLS-1:0]   pend_r;
   logic                   valid_r;
   logic [PWM_BITS-1:0]    bright_r;

   logic                   row_end_s;
   logic                   boundary_s;
   logic                   scan_nxt_s;
   logic [IDX_W-1:0]       row_idx_nxt_s;
   logic [PWM_BITS-1:0]    slot_nxt_s;
   logic [CYC_W-1:0]       cyc_nxt_s;
   logic [ROWS*COLS-1:0]   disp_nxt_s;
   logic [PWM_BITS-1:0]    bright_nxt_s;
   logic [COLS-1:0]        row_bits_s;
   logic [ROWS-1:0]        row_nxt_s;
   logic [COLS-1:0]        col_nxt_s;

   // Next scan position; the first SCAN entry counts as a frame boundary
   always_comb begin
      row_end_s     = (cyc_r == LAST_CYC) && (slot_r == LAST_SLOT);
      boundary_s    = 1'b0;
      row_idx_nxt_s = row_idx_r;
      slot_nxt_s    = slot_r;
      cyc_nxt_s     = cyc_r;
      case (state_r)
         HOLD: begin
            row_idx_nxt_s = {IDX_W{1'b0}};
            slot_nxt_s    = {PWM_BITS{1'b0}};
            cyc_nxt_s     = {CYC_W{1'b0}};
            if (hold_cnt_r == {HOLD_W{1'b0}}) begin
               boundary_s = 1'b1;
            end else begin
               boundary_s = 1'b0;
            end
         end
         SCAN: begin
            if (cyc_r == LAST_CYC) begin
               cyc_nxt_s  = {CYC_W{1'b0}};
               slot_nxt_s = slot_r + PWM_BITS'(1);
            end else begin
               cyc_nxt_s  = cyc_r + CYC_W'(1);
            end
            if (row_end_s && (row_idx_r == LAST_ROW)) begin
               row_idx_nxt_s = {IDX_W{1'b0}};
               boundary_s    = 1'b1;
            end else if (row_end_s) begin
               row_idx_nxt_s = row_idx_r + IDX_W'(1);
            end else begin
               row_idx_nxt_s = row_idx_r;
            end
         end
         default: begin
            boundary_s = 1'b0;
         end
      endcase
   end

   // Drive pattern for the position being entered, so the pins change together with the scan state
   always_comb begin
      disp_nxt_s   = (boundary_s && valid_r) ? pend_r : disp_r;
      bright_nxt_s = boundary_s ? brightness : bright_r;
      scan_nxt_s   = (state_r == SCAN) || boundary_s;
      row_bits_s   = {COLS{1'b0}};
      row_nxt_s    = {ROWS{1'b0}};
      for (int r = 0; r < ROWS; r++) begin
         if (row_idx_nxt_s == IDX_W'(r)) begin
            row_bits_s   = disp_nxt_s[r*COLS +: COLS];
            row_nxt_s[r] = scan_nxt_s;
         end else begin
            row_nxt_s[r] = 1'b0;
         end
      end
      if (!scan_nxt_s) begin
         col_nxt_s = {COLS{1'b1}};
`ifdef LED_SCAN_GHOST_BLANK_EN
      end else if ((slot_nxt_s == {PWM_BITS{1'b0}}) && (cyc_nxt_s == {CYC_W{1'b0}})) begin
         col_nxt_s = {COLS{1'b1}};
`endif
      end else if (slot_nxt_s <= bright_nxt_s) begin
         col_nxt_s = ~row_bits_s;
      end else begin
         col_nxt_s = {COLS{1'b1}};
      end
   end

   // Scan FSM, frame buffers and registered pin drive
   always_ff @(posedge system_clk) begin
      if (rst) begin
         state_r     <= HOLD;
         hold_cnt_r  <= HOLD_INIT;
         row_idx_r   <= {IDX_W{1'b0}};
         slot_r      <= {PWM_BITS{1'b0}};
         cyc_r       <= {CYC_W{1'b0}};
         disp_r      <= {(ROWS*COLS){1'b0}};
         pend_r      <= {(ROWS*COLS){1'b0}};
         valid_r     <= 1'b0;
         bright_r    <= {PWM_BITS{1'b0}};
         fb_ready    <= 1'b1;
         frame_start <= 1'b0;
         row         <= {ROWS{1'b0}};
         col         <= {COLS{1'b1}};
      end else begin
         case (state_r)
            HOLD: begin
               if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                  state_r <= SCAN;
               end else begin
                  state_r    <= HOLD;
                  hold_cnt_r <= hold_cnt_r - HOLD_W'(1);
               end
            end
            SCAN:    state_r <= SCAN;
            default: state_r <= HOLD;
         endcase
         row_idx_r <= row_idx_nxt_s;
         slot_r    <= slot_nxt_s;
         cyc_r     <= cyc_nxt_s;
         disp_r    <= disp_nxt_s;
         bright_r  <= bright_nxt_s;
         // fb_ready is the registered complement of valid_r, so a load in the swap cycle is refused
         if (boundary_s && valid_r) begin
            valid_r  <= 1'b0;
            fb_ready <= 1'b1;
         end else if (fb_load && fb_ready) begin
            pend_r   <= fb_in;
            valid_r  <= 1'b1;
            fb_ready <= 1'b0;
         end else begin
            valid_r  <= valid_r;
            fb_ready <= fb_ready;
         end
         frame_start <= boundary_s;
         row         <= row_nxt_s;
         col         <= col_nxt_s;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: timeline-arithmetic reference model plus directed scenarios.
module tb_led_matrix_scanner;

   localparam int ROWS     = 8;
   localparam int COLS     = 8;
   localparam int PWM_BITS = 3;
   localparam int SLOT_LEN = 4;
   localparam int POR      = 4;
   localparam int DWELL    = SLOT_LEN * (1 << PWM_BITS);
   localparam int FRAME    = DWELL * ROWS;
`ifdef LED_SCAN_GHOST_BLANK_EN
   localparam int GB = 1;
`else
   localparam int GB = 0;
`endif

   logic                 system_clk = 1'b0;
   logic                 rst = 1'b1;
   logic [ROWS*COLS-1:0] fb_in = '0;
   logic                 fb_load = 1'b0;
   logic [PWM_BITS-1:0]  brightness = '0;
   logic                 fb_ready;
   logic                 frame_start;
   logic [ROWS-1:0]      row;
   logic [COLS-1:0]      col;

   int checks = 0;
   int failures = 0;

   // reference model: position derived from edges since reset release
   int                   m_rel = 0;
   int                   m_s = -1;
   logic [ROWS*COLS-1:0] m_disp = '0;
   logic [ROWS*COLS-1:0] m_pend = '0;
   bit                   m_valid = 1'b0;
   int                   m_bright = 0;
   logic [ROWS-1:0]      exp_row = '0;
   logic [COLS-1:0]      exp_col = '1;
   logic                 exp_ready = 1'b1;
   logic                 exp_fs = 1'b0;

   led_matrix_scanner #(
      .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PWM_BITS), .SLOT_LEN(SLOT_LEN), .POR_CYCLES(POR)
   ) dut (
      .system_clk(system_clk), .rst(rst), .fb_in(fb_in), .fb_load(fb_load),
      .brightness(brightness), .fb_ready(fb_ready), .frame_start(frame_start),
      .row(row), .col(col)
   );

   always #5 system_clk = ~system_clk;

   // one clock edge, model update from the inputs sampled at that edge, then settle
   task automatic tick();
      bit bnd;
      bit acc;
      int d;
      int r;
      int slot;
      @(posedge system_clk);
      if (rst) begin
         m_rel = 0;
         m_s = -1;
         m_disp = '0;
         m_pend = '0;
         m_valid = 1'b0;
         m_bright = 0;
      end else begin
         m_rel++;
         m_s = m_rel - (POR + 1);
         bnd = (m_s >= 0) && (m_s % FRAME == 0);
         acc = fb_load && !m_valid;
         if (bnd && m_valid) begin
            m_disp = m_pend;
            m_valid = 1'b0;
         end
         if (acc) begin
            m_pend = fb_in;
            m_valid = 1'b1;
         end
         if (bnd) m_bright = int'(brightness);
      end
      exp_ready = !m_valid;
      if (m_s < 0) begin
         exp_row = '0;
         exp_col = '1;
         exp_fs = 1'b0;
      end else begin
         d = m_s % DWELL;
         r = (m_s / DWELL) % ROWS;
         slot = d / SLOT_LEN;
         exp_row = '0;
         exp_row[r] = 1'b1;
         exp_fs = (m_s % FRAME == 0);
         for (int c = 0; c < COLS; c++) exp_col[c] = !(m_disp[r*COLS+c] && (slot <= m_bright));
         if (GB == 1 && d == 0) exp_col = '1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fb_load = 1'b0;
      brightness = '0;
      repeat (3) tick();
      checks++;
      if ({row, col, fb_ready, frame_start} !== {8'h00, 8'hFF, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_values row=%h col=%h rdy=%b fs=%b expected 00 ff 1 0", row, col, fb_ready, frame_start);
      end
      rst = 1'b0;
      for (int i = 1; i <= POR + 2; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL reset_model i=%0d row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", i, row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         checks++;
         if (i <= POR) begin
            if (row !== 8'h00 || col !== 8'hFF) begin
               failures++;
               $display("FAIL hold_blank i=%0d row=%h col=%h expected 00 ff", i, row, col);
            end
         end else if (i == POR + 1) begin
            if (row !== 8'h01 || frame_start !== 1'b1 || col !== 8'hFF) begin
               failures++;
               $display("FAIL first_row row=%h fs=%b col=%h expected 01 1 ff", row, frame_start, col);
            end
         end else begin
            if (frame_start !== 1'b0 || row !== 8'h01) begin
               failures++;
               $display("FAIL fs_pulse fs=%b row=%h expected 0 01", frame_start, row);
            end
         end
      end
   endtask

   task automatic test_load_swap();
      int k;
      k = $urandom_range(150, 20);
      for (int i = 0; i < k; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL swap_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
      end
      brightness = 3'd7;
      fb_in = 64'h8100_0000_0000_0081;
      fb_load = 1'b1;
      tick();
      fb_load = 1'b0;
      fb_in = {$urandom, $urandom};
      checks++;
      if (fb_ready !== 1'b0) begin
         failures++;
         $display("FAIL ready_drop fb_ready=%b expected 0", fb_ready);
      end
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL swap_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (exp_fs) break;
      end
      checks++;
      if (fb_ready !== 1'b1 || frame_start !== 1'b1) begin
         failures++;
         $display("FAIL swap_ready fb_ready=%b fs=%b expected 1 1", fb_ready, frame_start);
      end
      for (int j = 1; j < FRAME; j++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL swap_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (j == 1 || j == 7 * DWELL + 1) begin
            checks++;
            if (col !== 8'h7E || row !== ((j == 1) ? 8'h01 : 8'h80)) begin
               failures++;
               $display("FAIL swap_pixels j=%0d row=%h col=%h expected col 7e", j, row, col);
            end
         end
      end
   endtask

   task automatic test_rejected_load();
      logic [63:0] a;
      logic [63:0] b;
      a = {$urandom, $urandom};
      b = ~a;
      for (int i = 0; i < int'($urandom_range(50, 10)); i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL reject_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
      end
      fb_in = a;
      fb_load = 1'b1;
      tick();
      fb_in = b;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (fb_ready !== 1'b0 || {row, col} !== {exp_row, exp_col}) begin
            failures++;
            $display("FAIL reject_busy fb_ready=%b expected 0 col=%h/%h", fb_ready, col, exp_col);
         end
      end
      fb_load = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL reject_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (exp_fs) break;
      end
      for (int j = 1; j < FRAME; j++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL reject_model row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (j == 2 || j == 4 * DWELL + 2) begin
            checks++;
            if (col !== ~a[(j / DWELL) * COLS +: COLS] || fb_ready !== 1'b1) begin
               failures++;
               $display("FAIL reject_data j=%0d col=%h expected %h rdy=%b", j, col, ~a[(j / DWELL) * COLS +: COLS], fb_ready);
            end
         end
      end
   endtask

   task automatic test_pwm(input int b);
      int cnt;
      for (int i = 0; i < 2 * FRAME && !exp_ready; i++) tick();
      brightness = PWM_BITS'(b);
      fb_in = '1;
      fb_load = 1'b1;
      tick();
      fb_load = 1'b0;
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL pwm_model b=%0d row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", b, row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (exp_fs) break;
      end
      cnt = (col[3] == 1'b0) ? 1 : 0;
      for (int j = 1; j < DWELL; j++) begin
         tick();
         if (col[3] == 1'b0) cnt++;
      end
      checks++;
      if (cnt != (b + 1) * SLOT_LEN - GB) begin
         failures++;
         $display("FAIL pwm_duty b=%0d low_cycles=%0d expected %0d", b, cnt, (b + 1) * SLOT_LEN - GB);
      end
   endtask

   task automatic test_mid_brightness();
      int cnt1;
      int cnt2;
      cnt1 = 0;
      cnt2 = 0;
      brightness = 3'd7;
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         if (exp_fs) break;
      end
      for (int j = 1; j < FRAME + DWELL; j++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL midb_model j=%0d row=%h/%h col=%h/%h fs=%b/%b", j, row, exp_row, col, exp_col, frame_start, exp_fs);
         end
         if (j == 3 * DWELL + 5) brightness = 3'd2;
         if (j >= 5 * DWELL && j < 6 * DWELL && col[0] == 1'b0) cnt1++;
         if (j >= FRAME && col[0] == 1'b0) cnt2++;
      end
      checks++;
      if (cnt1 != DWELL - GB) begin
         failures++;
         $display("FAIL midb_old low_cycles=%0d expected %0d", cnt1, DWELL - GB);
      end
      checks++;
      if (cnt2 != 3 * SLOT_LEN - GB) begin
         failures++;
         $display("FAIL midb_new low_cycles=%0d expected %0d", cnt2, 3 * SLOT_LEN - GB);
      end
   endtask

   task automatic test_reset_mid_scan();
      brightness = 3'd7;
      for (int i = 0; i < FRAME + 2; i++) begin
         tick();
         if (exp_fs) break;
      end
      fb_in = {$urandom, $urandom} | 64'h1;
      fb_load = 1'b1;
      tick();
      fb_load = 1'b0;
      repeat ($urandom_range(100, 5)) tick();
      rst = 1'b1;
      tick();
      checks++;
      if ({row, col, fb_ready, frame_start} !== {8'h00, 8'hFF, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL midrst_values row=%h col=%h rdy=%b fs=%b expected 00 ff 1 0", row, col, fb_ready, frame_start);
      end
      rst = 1'b0;
      for (int i = 1; i <= POR + 1 + DWELL; i++) begin
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL midrst_model i=%0d row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", i, row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
         if (i == POR + 3) begin
            checks++;
            if (row !== 8'h01 || col !== 8'hFF || fb_ready !== 1'b1) begin
               failures++;
               $display("FAIL midrst_blank row=%h col=%h rdy=%b expected 01 ff 1", row, col, fb_ready);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3 * FRAME; i++) begin
         fb_load = ($urandom_range(7, 0) == 0);
         fb_in = {$urandom, $urandom};
         if ($urandom_range(63, 0) == 0) brightness = PWM_BITS'($urandom);
         tick();
         checks++;
         if ({row, col, fb_ready, frame_start} !== {exp_row, exp_col, exp_ready, exp_fs}) begin
            failures++;
            $display("FAIL random_model i=%0d row=%h/%h col=%h/%h rdy=%b/%b fs=%b/%b", i, row, exp_row, col, exp_col, fb_ready, exp_ready, frame_start, exp_fs);
         end
      end
      fb_load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_swap();
      test_rejected_load();
      test_pwm(0);
      test_pwm(7);
      test_pwm(int'($urandom_range(6, 1)));
      test_mid_brightness();
      test_reset_mid_scan();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
